// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave pipelined Wishbone arbiter.
// Round-robin grant, registered, locked for the whole of the granted
// master's cyc window. Handing the grant to the other master costs no idle cycle.
// Optional watchdog: define WB_ARB2_TIMEOUT_EN to build the ack timeout
// counter and the ABORT state. Without it, timeout_o is tied low.
//
// Handshake: a request beat transfers in a cycle where cyc & stb are high
// and stall is low. A response is a cycle with ack high; read data is valid
// only with ack. A master that is not granted always sees stall=1 and ack=0,
// so its request is held off and never dropped.
module wb_arbiter2 #(
    parameter int TIMEOUT = 1024,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    // master 0
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [SW-1:0] m0_sel,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wdat,
    output logic [DW-1:0] m0_rdat,
    output logic          m0_ack,
    output logic          m0_stall,
    // master 1
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [SW-1:0] m1_sel,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wdat,
    output logic [DW-1:0] m1_rdat,
    output logic          m1_ack,
    output logic          m1_stall,
    // shared slave
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [SW-1:0] s_sel,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_wdat,
    input  logic [DW-1:0] s_rdat,
    input  logic          s_ack,
    input  logic          s_stall,
    // status
    output logic [1:0]    grant_o,
    output logic          timeout_o,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;   // most recently served master

    // Any elaboration that lands in this block was given an out-of-range TIMEOUT.
    if (TIMEOUT < 2) begin : g_timeout_too_small
    end

`ifdef WB_ARB2_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          gnt_cyc;
    logic          wd_fire;

    assign gnt_cyc = ((state_q == ST_GRANT0) && m0_cyc) ||
                     ((state_q == ST_GRANT1) && m1_cyc);
    // An ack on the terminal count wins over the timeout.
    assign wd_fire   = gnt_cyc && !s_ack && (cnt_q == CW'(TIMEOUT));
    assign timeout_o = wd_fire;

    // Watchdog counter: cleared outside or on entry to a grant and on every ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if ((state_q != ST_GRANT0 && state_q != ST_GRANT1) ||
                     (state_d != state_q) || s_ack) begin
            cnt_q <= '0;
        end else if (gnt_cyc) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

    // State and last-served registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state: arbitrate from IDLE, hold lock, hand off on cyc release.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) state_d = last_q ? ST_GRANT0 : ST_GRANT1;
                else if (m0_cyc)      state_d = ST_GRANT0;
                else if (m1_cyc)      state_d = ST_GRANT1;
            end
            ST_GRANT0: begin
                if (!m0_cyc) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc ? ST_GRANT1 : ST_IDLE;
                end
`ifdef WB_ARB2_TIMEOUT_EN
                else if (wd_fire) begin
                    // last records the offender so ABORT knows whose cyc to watch
                    last_d  = 1'b0;
                    state_d = ST_ABORT;
                end
`endif
            end
            ST_GRANT1: begin
                if (!m1_cyc) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc ? ST_GRANT0 : ST_IDLE;
                end
`ifdef WB_ARB2_TIMEOUT_EN
                else if (wd_fire) begin
                    last_d  = 1'b1;
                    state_d = ST_ABORT;
                end
`endif
            end
            default: begin
`ifdef WB_ARB2_TIMEOUT_EN
                if (!(last_q ? m1_cyc : m0_cyc)) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    // Outputs: steer the granted master through, hold everyone else off.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_sel    = '0;
        s_adr    = '0;
        s_wdat   = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_stall = 1'b1;
        m1_stall = 1'b1;
        m0_rdat  = '0;
        m1_rdat  = '0;
        grant_o  = 2'b00;
        case (state_q)
            ST_GRANT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_sel    = m0_sel;
                s_adr    = m0_adr;
                s_wdat   = m0_wdat;
                m0_ack   = s_ack;
                m0_stall = s_stall;
                m0_rdat  = s_rdat;
                grant_o  = 2'b01;
            end
            ST_GRANT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_sel    = m1_sel;
                s_adr    = m1_adr;
                s_wdat   = m1_wdat;
                m1_ack   = s_ack;
                m1_stall = s_stall;
                m1_rdat  = s_rdat;
                grant_o  = 2'b10;
            end
            default: begin
                grant_o = 2'b00;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: reset, tie/round-robin, single-master
// pipelined read, locked write burst, reset mid-transfer and the watchdog
// (or, when WB_ARB2_TIMEOUT_EN is undefined, the absence of one).
module tb_wb_arbiter2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_wdat, m0_rdat;
    logic        m0_ack, m0_stall;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_wdat, m1_rdat;
    logic        m1_ack, m1_stall;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic        s_ack, s_stall;
    logic [1:0]  grant_o;
    logic        timeout_o;
    logic [1:0]  state_dbg;

    int n_vec;
    int n_err;

    wb_arbiter2 #(.TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_adr(m0_adr), .m0_wdat(m0_wdat), .m0_rdat(m0_rdat),
        .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_adr(m1_adr), .m1_wdat(m1_wdat), .m1_rdat(m1_rdat),
        .m1_ack(m1_ack), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_wdat(s_wdat), .s_rdat(s_rdat),
        .s_ack(s_ack), .s_stall(s_stall),
        .grant_o(grant_o), .timeout_o(timeout_o), .state_dbg(state_dbg)
    );

    // Clock.
    always #5 clk_i = ~clk_i;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_adr = 0; m0_wdat = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_adr = 0; m1_wdat = 0;
        s_rdat = 0; s_ack = 0; s_stall = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_all();

        // ---- reset with both masters requesting ----
        rst_i = 1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_grant", grant_o, 32'h0);
            check("rst_scyc", s_cyc, 32'h0);
            check("rst_m0stall", m0_stall, 32'h1);
            check("rst_m1stall", m1_stall, 32'h1);
            check("rst_timeout", timeout_o, 32'h0);
            check("rst_m0ack", m0_ack, 32'h0);
        end
        rst_i = 0;
        #1;
        check("rst_rel_grant", grant_o, 32'h0);

        // ---- tie after reset: m0 first, then m1 with no gap ----
        tick();
        check("tie1_grant", grant_o, 32'h1);
        check("tie1_scyc", s_cyc, 32'h1);
        check("tie1_sadr", s_adr, 32'h10);
        check("tie1_m1stall", m1_stall, 32'h1);
        m0_cyc = 0; m0_stb = 0;
        #1;
        check("release_scyc", s_cyc, 32'h0);
        tick();
        check("handoff_grant", grant_o, 32'h2);
        check("handoff_sadr", s_adr, 32'h20);
        check("handoff_scyc", s_cyc, 32'h1);
        m1_cyc = 0; m1_stb = 0;
        tick();
        check("idle_grant", grant_o, 32'h0);
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        check("tie2_grant", grant_o, 32'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        check("tie2_idle", grant_o, 32'h0);

        // ---- m1 4-beat pipelined read ----
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h4000_0000;
        #1;
        check("rd_wait_stall", m1_stall, 32'h1);
        check("rd_wait_sstb", s_stb, 32'h0);
        tick();
        check("rd_grant", grant_o, 32'h2);
        check("rd_sstb", s_stb, 32'h1);
        check("rd_sadr0", s_adr, 32'h4000_0000);
        check("rd_swe", s_we, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) m1_adr = 32'h4000_0000 + 32'(4 * k);
            else m1_stb = 0;
            s_ack = 1;
            s_rdat = 32'hA0 + 32'(k - 1);
            #1;
            check("rd_m1ack", m1_ack, 32'h1);
            check("rd_m1rdat", m1_rdat, 32'hA0 + 32'(k - 1));
            check("rd_m0ack", m0_ack, 32'h0);
            check("rd_sstb_beat", s_stb, (k < 4) ? 32'h1 : 32'h0);
        end
        tick();
        m1_cyc = 0; s_ack = 0;
        #1;
        check("rd_end_ack", m1_ack, 32'h0);
        check("rd_end_scyc", s_cyc, 32'h0);
        tick();

        // ---- m0 8-write locked burst, m1 arrives mid-way ----
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h100;
        tick();
        check("wr_grant", grant_o, 32'h1);
        for (int i = 0; i < 8; i++) begin
            m0_adr = 32'h100 + 32'(4 * i);
            m0_sel = 4'(1 << (i % 4));
            m0_wdat = 32'hD000 + 32'(i);
            s_ack = 1;
            if (i == 3) begin
                m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h200;
                m1_wdat = 32'h55; m1_sel = 4'hF;
            end
            #1;
            check("wr_sadr", s_adr, 32'h100 + 32'(4 * i));
            check("wr_ssel", s_sel, 32'(1 << (i % 4)));
            check("wr_swdat", s_wdat, 32'hD000 + 32'(i));
            check("wr_swe", s_we, 32'h1);
            check("wr_m0ack", m0_ack, 32'h1);
            if (i >= 3) begin
                check("lock_m1stall", m1_stall, 32'h1);
                check("lock_m1ack", m1_ack, 32'h0);
                check("lock_grant", grant_o, 32'h1);
            end
            tick();
        end
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        #1;
        check("lock_rel_scyc", s_cyc, 32'h0);
        check("lock_rel_m1stall", m1_stall, 32'h1);
        tick();
        check("held_grant", grant_o, 32'h2);
        check("held_sadr", s_adr, 32'h200);
        check("held_swdat", s_wdat, 32'h55);
        check("held_ssel", s_sel, 32'hF);
        check("held_swe", s_we, 32'h1);
        s_ack = 1;
        #1;
        check("held_m1ack", m1_ack, 32'h1);
        check("held_m1stall", m1_stall, 32'h0);
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        tick();
        check("held_idle", grant_o, 32'h0);

        // ---- reset mid-transfer, then a late ack ----
        m0_cyc = 1; m0_stb = 1; m0_we = 0;
        tick();
        check("mid_grant", grant_o, 32'h1);
        rst_i = 1;
        tick();
        rst_i = 0; m0_cyc = 0; m0_stb = 0; s_ack = 1;
        #1;
        check("mid_rst_grant", grant_o, 32'h0);
        check("mid_late_ack", m0_ack, 32'h0);
        check("mid_rst_scyc", s_cyc, 32'h0);
        tick();
        check("mid_idle_grant", grant_o, 32'h0);
        check("mid_idle_ack", m0_ack, 32'h0);
        s_ack = 0;

`ifdef WB_ARB2_TIMEOUT_EN
        // ---- watchdog fires on a hung slave ----
        s_stall = 1;
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int k = 0; k < 16; k++) begin
            check("wd_pre_timeout", timeout_o, 32'h0);
            check("wd_pre_grant", grant_o, 32'h1);
            tick();
        end
        check("wd_fire", timeout_o, 32'h1);
        check("wd_fire_grant", grant_o, 32'h1);
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h300;
        tick();
        check("abort_grant", grant_o, 32'h0);
        check("abort_scyc", s_cyc, 32'h0);
        check("abort_timeout", timeout_o, 32'h0);
        check("abort_state", state_dbg, 32'h3);
        check("abort_m0stall", m0_stall, 32'h1);
        check("abort_m1stall", m1_stall, 32'h1);
        s_ack = 1;
        #1;
        check("abort_m0ack", m0_ack, 32'h0);
        check("abort_m1ack", m1_ack, 32'h0);
        tick();
        s_ack = 0;
        check("abort_hold", grant_o, 32'h0);
        m0_cyc = 0; m0_stb = 0;
        tick();
        check("abort_exit_idle", grant_o, 32'h0);
        tick();
        check("abort_m1_grant", grant_o, 32'h2);
        check("abort_m1_sadr", s_adr, 32'h300);

        // ---- ack on count 15 clears the watchdog, twice ----
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 15; k++) begin
                check("late_no_timeout", timeout_o, 32'h0);
                tick();
            end
            s_ack = 1;
            #1;
            check("late_ack_timeout", timeout_o, 32'h0);
            tick();
            s_ack = 0;
        end
        check("late_end_timeout", timeout_o, 32'h0);
        check("late_end_grant", grant_o, 32'h2);
        m1_cyc = 0; m1_stb = 0; s_stall = 0;
        tick();
`else
        // ---- no watchdog: a hung slave keeps the grant ----
        s_stall = 1;
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int k = 0; k < 24; k++) begin
            check("hang_timeout", timeout_o, 32'h0);
            check("hang_grant", grant_o, 32'h1);
            check("hang_scyc", s_cyc, 32'h1);
            tick();
        end
        m0_cyc = 0; m0_stb = 0; s_stall = 0;
        tick();
`endif
        check("final_idle", grant_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave pipelined Wishbone arbiter that shares a single `if_wb` slave between two requesters, e.g. the CPU data-bus port of `mmu_bus1` and a future DMA/video master in front of `sdram32_controller_cache`. Grant is round-robin, registered, and locked for the whole of a master's `cyc` window. An optional watchdog aborts a granted cycle that stops receiving acks.

## Interface

Parameters:
- `TIMEOUT`, default 1024: cycles without slave `ack` while granted before the watchdog fires. Must be ≥ 2; counter width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `m0`  if_wb.slave  –  master 0 port; wins the tie after reset.
- `m1`  if_wb.slave  –  master 1 port.
- `s`  if_wb.master  –  shared slave port.
- `grant_o`  out  2  one-hot current grant: `2'b01` = m0, `2'b10` = m1, `2'b00` = none.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires; intended for `interrupt_encoder`.

## Operation

- States: IDLE, GRANT0, GRANT1, ABORT. A `last` flag records the most recently served master.
- **IDLE**
  - `s.cyc` = `s.stb` = 0.
  - Both master `stall` = 1 while that master's `cyc` is 1; both `ack` = 0.
  - If exactly one master has `cyc`=1, go to that master's GRANT state.
  - If both do, go to the master other than `last`.
  - After reset `last` = 1, so m0 wins the first tie.
- **GRANTx**
  - Master x's `cyc`, `stb`, `we`, `sel`, `adr` and write data pass combinationally to `s`.
  - `s.ack`, `s.stall` and read data pass combinationally back to master x.
  - The non-granted master sees `stall` = 1 and `ack` = 0; its requests are held off, never dropped.
  - Grant holds while master x `cyc` = 1, regardless of the other master.
- **Release**: in the cycle master x drops `cyc`:
  - `s.cyc` = 0 combinationally that cycle.
  - `last` ← x.
  - Next state is the other master's GRANT if its `cyc` = 1, else IDLE. Handoff has no idle cycle.
- Read data muxing is selected by the registered state only. The arbiter never reorders or buffers transactions.
- **ABORT** (watchdog builds only)
  - `s.cyc` = 0.
  - The offending master sees `stall` = 1 and `ack` = 0.
  - Exit to IDLE (`last` ← x) when that master drops `cyc`.
  - The other master is not served until then.
- `grant_o` decodes the state: GRANT0 → 01, GRANT1 → 10, IDLE/ABORT → 00.

## Timing

- **Reset values**: state IDLE, `last` = 1, `grant_o` = 00, `timeout_o` = 0.
  - `s.cyc`, `s.stb`, `s.we` = 0.
  - `m0`/`m1` `ack` = 0; `stall` = 1 while that master's `cyc` = 1.
- **Reset mid-transfer**: on the first cycle `rst_i` is sampled high, all state returns to IDLE. Outstanding slave acks arriving afterwards are discarded.
- **Arbitration latency**: master `cyc`/`stb` first high in cycle N (from IDLE) → `s.cyc`/`s.stb` high in cycle N+1. The master's first `stb` is stalled exactly one cycle.
- **Handoff**: m0 drops `cyc` in cycle N while m1 is requesting → m1 drives `s` in cycle N+1.
- **Same-cycle requests from IDLE**: resolved by `last` only; no starvation. Each master is served at most one locked cycle in a row while the other waits.
- `s.ack` arriving in IDLE or ABORT is ignored.

## Configuration

- Macro `WB_ARB2_TIMEOUT_EN`.
- **Defined**:
  - The watchdog counter is cleared on entry to any GRANT state and on every `s.ack`.
  - It increments each GRANT cycle with `s.cyc` = 1 and `s.ack` = 0.
  - On reaching `TIMEOUT`: `timeout_o` = 1 for that single cycle, and the next state is ABORT.
  - An `ack` in the same cycle as the terminal count wins: the counter clears and there is no timeout.
- **Undefined**: no counter or ABORT logic is built; `timeout_o` is tied 0; a hung slave holds the grant indefinitely.

## Test plan

- **Reset**: `rst_i` high 3 cycles with both `cyc` = 1 → `grant_o` = 00, `s.cyc` = 0, both `stall` = 1. Release → `grant_o` = 01 one cycle later.
- **Single master**: m1 does a 4-beat pipelined read from `adr` 0x40000000 (slave returns 0xA0..0xA3) → `s.stb` asserted one cycle after m1 `stb`. m1 receives 4 acks in order with data 0xA0..0xA3. m0 sees `ack` = 0 throughout.
- **Tie / round-robin**: both masters raise `cyc` in the same cycle after reset → m0 granted first. m0 drops `cyc` → m1 granted the very next cycle. Repeat the tie → m0 granted again (`last` = m1).
- **Lock**: m1 raises `cyc` mid-way through an 8-write m0 burst → m1 stalled until m0 drops `cyc`. All 8 m0 writes reach `s` with correct `adr`/`sel`/data. m1's held write then completes.
- **Watchdog** (`WB_ARB2_TIMEOUT_EN`, `TIMEOUT` = 16): slave never acks → `timeout_o` pulses 16 cycles after the GRANT entry, `s.cyc` drops, state is ABORT. After the master drops `cyc`, a pending m1 request is granted two cycles later (via IDLE).
- **Late ack**: with the same settings, `s.ack` arrives at count 15 → no timeout, counter cleared; a second stall of 15 cycles also passes without timeout.
